wb_coproc_seq: RTL and testbench

- Wishbone classic master that sequences one complete coprocessor operation per command.
- Each operation is: write operand A (0x00), write operand B (0x04), read the selected result (0x08/0x0C/0x10/0x14).
- Sits between a simple valid/ready command source and the coprocessor slave port.
- Gives the requester a single-transaction interface with a bus-timeout error path.

---
 rtl/wb_coproc_seq.sv | 209 ++++++++++++++++++++
 tb/tb_wb_coproc_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_coproc_seq.sv
// Wishbone classic master that runs one coprocessor operation per command:
// write A, write B, read result. Optional operand cache: WB_COPROC_SEQ_OPCACHE_EN.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// WR_A   | writing operand A to 0x00
// WR_B   | writing operand B to 0x04
// RD     | reading the selected result (0x08 + 4*op)
// RESP   | holding the response until rsp_ready
module wb_coproc_seq #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_opa,
  input  logic [31:0] cmd_opb,
  input  logic [1:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {S_IDLE, S_WR_A, S_WR_B, S_RD, S_RESP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  state_t          first_st, after_a;
  logic [31:0]     opa_q, opa_d, opb_q, opb_d;
  logic [1:0]      op_q, op_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            in_xfer, to_hit;

  assign in_xfer = (state_q == S_WR_A) || (state_q == S_WR_B) || (state_q == S_RD);
  // An ack arriving in the final cycle wins over the timeout.
  assign to_hit  = in_xfer && !wb_ack_i && (to_cnt_q == TO_LAST);

`ifdef WB_COPROC_SEQ_OPCACHE_EN
  logic [31:0] last_a_q, last_a_d, last_b_q, last_b_d;
  logic        va_q, va_d, vb_q, vb_d, skip_b_q, skip_b_d;
  logic        hit_a, hit_b;

  assign hit_a   = va_q && (cmd_opa == last_a_q);
  assign hit_b   = vb_q && (cmd_opb == last_b_q);
  assign after_a = skip_b_q ? S_RD : S_WR_B;

  always_comb begin
    first_st = S_RD;
    if (!hit_a)      first_st = S_WR_A;
    else if (!hit_b) first_st = S_WR_B;
  end

  always_comb begin
    last_a_d = last_a_q;
    last_b_d = last_b_q;
    va_d     = va_q;
    vb_d     = vb_q;
    skip_b_d = skip_b_q;
    if (state_q == S_IDLE && cmd_valid) skip_b_d = hit_b;
    if (state_q == S_WR_A && wb_ack_i) begin
      last_a_d = opa_q;
      va_d     = 1'b1;
    end
    if (state_q == S_WR_B && wb_ack_i) begin
      last_b_d = opb_q;
      vb_d     = 1'b1;
    end
    if (to_hit) begin
      va_d = 1'b0;
      vb_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_a_q <= '0;
      last_b_q <= '0;
      va_q     <= 1'b0;
      vb_q     <= 1'b0;
      skip_b_q <= 1'b0;
    end else begin
      last_a_q <= last_a_d;
      last_b_q <= last_b_d;
      va_q     <= va_d;
      vb_q     <= vb_d;
      skip_b_q <= skip_b_d;
    end
  end
`else
  assign first_st = S_WR_A;
  assign after_a  = S_WR_B;
`endif

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    to_cnt_d   = to_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          opa_d    = cmd_opa;
          opb_d    = cmd_opb;
          op_d     = cmd_op;
          state_d  = first_st;
          to_cnt_d = '0;
        end
      end
      S_WR_A, S_WR_B, S_RD: begin
        if (wb_ack_i) begin
          to_cnt_d = '0;
          if (state_q == S_WR_A) begin
            state_d = after_a;
          end else if (state_q == S_WR_B) begin
            state_d = S_RD;
          end else begin
            state_d    = S_RESP;
            rsp_data_d = wb_dat_i;
            rsp_err_d  = 1'b0;
          end
        end else if (to_hit) begin
          state_d    = S_RESP;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          to_cnt_d   = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      op_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Bus signals depend on the registered state only, so they never glitch with inputs.
  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    case (state_q)
      S_WR_A: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_adr_o = 5'h00;
        wb_dat_o = opa_q;
      end
      S_WR_B: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_adr_o = 5'h04;
        wb_dat_o = opb_q;
      end
      S_RD: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_adr_o = 5'h08 + {1'b0, op_q, 2'b00};
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_coproc_seq.sv
// Directed bench for wb_coproc_seq with a one-cycle-ack coprocessor slave model.
module tb_wb_coproc_seq;

`ifdef WB_COPROC_SEQ_OPCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_opa, cmd_opb;
  logic [1:0]  cmd_op;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic        wb_ack_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_coproc_seq #(.TIMEOUT(15), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  // Coprocessor slave: registered one-cycle ack with ~ack guard.
  typedef struct {
    logic        we;
    logic [4:0]  adr;
    logic [31:0] dat;
  } xfer_t;

  xfer_t       log_q[$];
  logic [31:0] reg_a = '0, reg_b = '0;
  logic        ack_q;
  logic        slave_en;

  assign wb_ack_i = ack_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_q <= 1'b0;
    else        ack_q <= slave_en && wb_cyc_o && wb_stb_o && !ack_q;
  end

  always @(posedge clk) begin
    if (rst_n && ack_q && wb_cyc_o && wb_stb_o) begin
      log_q.push_back('{wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : wb_dat_i});
      if (wb_we_o && wb_adr_o == 5'h00) reg_a <= wb_dat_o;
      if (wb_we_o && wb_adr_o == 5'h04) reg_b <= wb_dat_o;
    end
  end

  always_comb begin
    wb_dat_i = '0;
    case (wb_adr_o)
      5'h08: wb_dat_i = reg_a >> reg_b;
      5'h0C: wb_dat_i = reg_a & reg_b;
      5'h10: wb_dat_i = reg_a | reg_b;
      5'h14: wb_dat_i = reg_a ^ reg_b;
      default: wb_dat_i = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lg_adr(input int i);
    if (i >= 0 && i < log_q.size()) return 32'(log_q[i].adr);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lg_dat(input int i);
    if (i >= 0 && i < log_q.size()) return log_q[i].dat;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lg_we(input int i);
    if (i >= 0 && i < log_q.size()) return 32'(log_q[i].we);
    return 32'hDEAD_BEEF;
  endfunction

  // Handshake edge is cycle 0; lat is the first cycle rsp_valid is seen.
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          output int lat, output int stbn);
    int guard;
    log_q.delete();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_opa   = a;
    cmd_opb   = b;
    cmd_op    = op;
    guard     = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat  = 0;
    stbn = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (wb_stb_o) stbn++;
      if (rsp_valid) break;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_rsp", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, stbn, guard;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_opa   = '0;
    cmd_opb   = '0;
    cmd_op    = '0;
    rsp_ready = 1'b0;
    slave_en  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_cyc", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_adr", 32'(wb_adr_o), 32'd0);
    rst_n = 1'b1;

    // AND, full sequence
    send_cmd(32'hF0F0_00FF, 32'h0FF0_FF0F, 2'd1, lat, stbn);
    chk("and_lat", 32'(lat), 32'd7);
    chk("and_stb_cycles", 32'(stbn), 32'd6);
    chk("and_nxfer", 32'(log_q.size()), 32'd3);
    chk("and_x0_we", lg_we(0), 32'd1);
    chk("and_x0_adr", lg_adr(0), 32'h00);
    chk("and_x0_dat", lg_dat(0), 32'hF0F0_00FF);
    chk("and_x1_adr", lg_adr(1), 32'h04);
    chk("and_x1_dat", lg_dat(1), 32'h0FF0_FF0F);
    chk("and_x2_we", lg_we(2), 32'd0);
    chk("and_x2_adr", lg_adr(2), 32'h0C);
    chk("and_data", rsp_data, 32'h00F0_000F);
    chk("and_err", 32'(rsp_err), 32'd0);
    take_rsp();

    // XOR, OR, SRL on same operands
    send_cmd(32'hF0F0_00FF, 32'h0FF0_FF0F, 2'd3, lat, stbn);
    chk("xor_lat", 32'(lat), CACHE ? 32'd3 : 32'd7);
    chk("xor_nxfer", 32'(log_q.size()), CACHE ? 32'd1 : 32'd3);
    chk("xor_rd_adr", lg_adr(log_q.size() - 1), 32'h14);
    chk("xor_data", rsp_data, 32'hFF00_FFF0);
    take_rsp();

    send_cmd(32'hF0F0_00FF, 32'h0FF0_FF0F, 2'd2, lat, stbn);
    chk("or_nxfer", 32'(log_q.size()), CACHE ? 32'd1 : 32'd3);
    chk("or_rd_adr", lg_adr(log_q.size() - 1), 32'h10);
    chk("or_data", rsp_data, 32'hFFF0_FFFF);
    take_rsp();

    send_cmd(32'hF0F0_00FF, 32'h0FF0_FF0F, 2'd0, lat, stbn);
    chk("srl_rd_adr", lg_adr(log_q.size() - 1), 32'h08);
    chk("srl_data", rsp_data, 32'h0000_0000);
    take_rsp();

    // Timeout in WR_A; opb matches the cache so a stale vb would show up next
    slave_en = 1'b0;
    send_cmd(32'h1234_5678, 32'h0FF0_FF0F, 2'd1, lat, stbn);
    chk("to_lat", 32'(lat), 32'd16);
    chk("to_stb_cycles", 32'(stbn), 32'd15);
    chk("to_released", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("to_nxfer", 32'(log_q.size()), 32'd0);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_data", rsp_data, 32'd0);
    take_rsp();
    slave_en = 1'b1;

    send_cmd(32'h1234_5678, 32'h0FF0_FF0F, 2'd1, lat, stbn);
    chk("post_to_lat", 32'(lat), 32'd7);
    chk("post_to_nxfer", 32'(log_q.size()), 32'd3);
    chk("post_to_x1_adr", lg_adr(1), 32'h04);
    chk("post_to_data", rsp_data, 32'h0230_5608);
    chk("post_to_err", 32'(rsp_err), 32'd0);
    take_rsp();

    // Response held for 10 cycles with a command waiting
    send_cmd(32'h1234_5678, 32'h0FF0_FF0F, 2'd3, lat, stbn);
    chk("hold_valid0", 32'(rsp_valid), 32'd1);
    cmd_valid = 1'b1;
    cmd_opa   = 32'h1234_5678;
    cmd_opb   = 32'h0FF0_FF0F;
    cmd_op    = 2'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, 32'h1DC4_A977);
      chk("hold_err", 32'(rsp_err), 32'd0);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("hold_idle_ready", 32'(cmd_ready), 32'd1);
    chk("hold_idle_stb", 32'(wb_stb_o), 32'd0);
    log_q.delete();
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("hold_next_stb", 32'(wb_stb_o), 32'd1);
    chk("hold_next_adr", 32'(wb_adr_o), CACHE ? 32'h0C : 32'h00);
    guard = 0;
    while (!rsp_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("hold_next_data", rsp_data, 32'h0230_5608);
    take_rsp();

    // Reset during WR_B
    log_q.delete();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_opa   = 32'hAAAA_5555;
    cmd_opb   = 32'h0000_0004;
    cmd_op    = 2'd0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    guard = 0;
    while (!(wb_stb_o && wb_adr_o == 5'h04) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_mid_in_wrb", 32'(wb_adr_o), 32'h04);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bus", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    send_cmd(32'hAAAA_5555, 32'h0000_0004, 2'd0, lat, stbn);
    chk("after_rst_lat", 32'(lat), 32'd7);
    chk("after_rst_nxfer", 32'(log_q.size()), 32'd3);
    chk("after_rst_x0_adr", lg_adr(0), 32'h00);
    chk("after_rst_x0_dat", lg_dat(0), 32'hAAAA_5555);
    chk("after_rst_data", rsp_data, 32'h0AAA_A555);
    take_rsp();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
